// File: rtl/sysref_pkg.sv
`default_nettype none
// ============================================================================
// sysref_pkg: shared FSM state encoding and default sizing for sysref_aligner
// Rev 1.0
// ============================================================================
package sysref_pkg;

  typedef logic [1:0] sysref_state_t;

  localparam sysref_state_t WAIT_FIRST = 2'd0;
  localparam sysref_state_t MEASURE    = 2'd1;
  localparam sysref_state_t VERIFY     = 2'd2;
  localparam sysref_state_t LOCKED     = 2'd3;

  localparam int DEF_PERIOD_W   = 16;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_MIN_PERIOD = 8;

endpackage
`default_nettype wire

// File: rtl/sysref_edge_det.sv
`default_nettype none
// ============================================================================
// sysref_edge_det: registers captured SYSREF and flags its rising edges
// Rev 1.0
// ============================================================================
module sysref_edge_det (
  input  logic pl_clk,
  input  logic pl_rst,
  input  logic sysref_in,
  output logic det
);

  logic sysref_d;
  logic sysref_q;

  always_comb begin
    sysref_d = sysref_in;
  end

  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      sysref_q <= 1'b0;
    end else begin
      sysref_q <= sysref_d;
    end
  end

  assign det = sysref_in & ~sysref_q;

endmodule
`default_nettype wire

// File: rtl/sysref_aligner.sv
`default_nettype none
// ============================================================================
// sysref_aligner: learns/verifies SYSREF period, emits aligned LMFC pulse
// Rev 1.0
// ============================================================================
module sysref_aligner
  import sysref_pkg::*;
#(
  parameter int PERIOD_W   = DEF_PERIOD_W,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
  input  logic                pl_clk,
  input  logic                pl_rst,
  input  logic                sysref_in,
  input  logic                rearm,
  input  logic                clear_err,
  output logic                sysref_edge,
  output logic                lmfc_pulse,
  output logic                locked,
  output logic [PERIOD_W-1:0] period,
  output logic                phase_err,
  output logic                timeout,
  output logic [7:0]          err_count
);

  localparam logic [PERIOD_W-1:0] ICNT_MAX  = {PERIOD_W{1'b1}};
  localparam logic [PERIOD_W-1:0] ONE       = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);
  localparam logic [3:0]          LOCK_LAST = 4'(LOCK_COUNT - 1);

  logic det;

  sysref_edge_det u_edge_det (
    .pl_clk    (pl_clk),
    .pl_rst    (pl_rst),
    .sysref_in (sysref_in),
    .det       (det)
  );

  sysref_state_t       state_d, state_q;
  logic [PERIOD_W-1:0] icnt_d, icnt_q;
  logic [PERIOD_W-1:0] ph_d, ph_q;
  logic [PERIOD_W-1:0] period_d, period_q;
  logic [3:0]          match_d, match_q;
  logic                sysref_edge_d, sysref_edge_q;
  logic                lmfc_pulse_d, lmfc_pulse_q;
  logic                locked_d, locked_q;
  logic                phase_err_d, phase_err_q;
  logic                timeout_d, timeout_q;
  logic [7:0]          err_count_d, err_count_q;

  logic [PERIOD_W-1:0] interval;
  logic                icnt_sat;
  logic                err_evt;
  logic                perr_evt;
  logic                tout_evt;

  assign interval = icnt_q + ONE;
  assign icnt_sat = (icnt_q == ICNT_MAX);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    match_d  = match_q;
    err_evt  = 1'b0;
    perr_evt = 1'b0;
    tout_evt = 1'b0;
    icnt_d   = det ? '0 : (icnt_sat ? icnt_q : icnt_q + ONE);
    ph_d     = (ph_q == period_q - ONE) ? '0 : ph_q + ONE;

    // Priority: rearm, then saturation timeout, then edge handling.
    if (rearm) begin
      state_d  = WAIT_FIRST;
      period_d = '0;
      match_d  = '0;
    end else if (icnt_sat && (state_q != WAIT_FIRST)) begin
      tout_evt = 1'b1;
      if (state_q == LOCKED) begin
        perr_evt = 1'b1;
        err_evt  = 1'b1;
      end
      state_d = WAIT_FIRST;
    end else if (det) begin
      case (state_q)
        WAIT_FIRST: state_d = MEASURE;
        MEASURE: begin
          if (interval < MIN_P) begin
            err_evt = 1'b1;
          end else begin
            period_d = interval;
            match_d  = '0;
            state_d  = VERIFY;
          end
        end
        VERIFY: begin
          if (interval == period_q) begin
            if (match_q == LOCK_LAST) begin
              // The locking edge itself is phase 0, so the next cycle is phase 1.
              state_d = LOCKED;
              match_d = '0;
              ph_d    = ONE;
            end else begin
              match_d = match_q + 4'd1;
            end
          end else begin
            if (interval >= MIN_P) begin
              period_d = interval;
            end
            match_d = '0;
          end
        end
        default: begin
          if (ph_q != '0) begin
            perr_evt = 1'b1;
            err_evt  = 1'b1;
            state_d  = MEASURE;
          end
        end
      endcase
    end

    if (state_d != LOCKED) begin
      ph_d = '0;
    end

    sysref_edge_d = det;
    locked_d      = (state_d == LOCKED);
    lmfc_pulse_d  = (state_d == LOCKED) && ((state_q != LOCKED) || (ph_q == '0));
    phase_err_d   = perr_evt | (phase_err_q & ~clear_err);
    timeout_d     = tout_evt | (timeout_q & ~clear_err);

    if (clear_err) begin
      err_count_d = err_evt ? 8'd1 : 8'd0;
    end else if (err_evt && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      state_q       <= WAIT_FIRST;
      icnt_q        <= '0;
      ph_q          <= '0;
      period_q      <= '0;
      match_q       <= '0;
      sysref_edge_q <= 1'b0;
      lmfc_pulse_q  <= 1'b0;
      locked_q      <= 1'b0;
      phase_err_q   <= 1'b0;
      timeout_q     <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      icnt_q        <= icnt_d;
      ph_q          <= ph_d;
      period_q      <= period_d;
      match_q       <= match_d;
      sysref_edge_q <= sysref_edge_d;
      lmfc_pulse_q  <= lmfc_pulse_d;
      locked_q      <= locked_d;
      phase_err_q   <= phase_err_d;
      timeout_q     <= timeout_d;
      err_count_q   <= err_count_d;
    end
  end

  assign sysref_edge = sysref_edge_q;
  assign lmfc_pulse  = lmfc_pulse_q;
  assign locked      = locked_q;
  assign period      = period_q;
  assign phase_err   = phase_err_q;
  assign timeout     = timeout_q;
  assign err_count   = err_count_q;

endmodule
`default_nettype wire
